id_register_file: RTL and testbench

ID_REGISTER_FILE -- requirements
Module: id_register_file

---
 rtl/id_register_file.sv | 121 ++++++++++++
 tb/tb_id_register_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/id_register_file.sv
// ----------------------------------------------------------------------------
// id_register_file
//
// Purpose:
//   Pipeline register file sitting between decode (ID) and execute (EX).
//   It holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. Register 0 always
//   reads as zero. The register file has one write-back port and two
//   registered read ports with write-first bypass. A stall input freezes
//   the read outputs without blocking array writes.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   rst_n          in   asynchronous active-low reset; clears array and outputs
//   RegWrite_WB    in   write-back enable
//   Write_Reg_WB   in   write-back destination index
//   Write_Data_WB  in   write-back data
//   Read_Reg1_ID   in   source index rs
//   Read_Reg2_ID   in   source index rt
//   Stall_ID       in   hold read outputs (and bypass flags) when high
//   Read_Data1_EX  out  registered rs value
//   Read_Data2_EX  out  registered rt value
//   Bypass1_EX     out  Read_Data1_EX came from the write-back port
//   Bypass2_EX     out  Read_Data2_EX came from the write-back port
// ----------------------------------------------------------------------------
module id_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite_WB,
    input  logic [ADDR_WIDTH-1:0] Write_Reg_WB,
    input  logic [DATA_WIDTH-1:0] Write_Data_WB,
    input  logic [ADDR_WIDTH-1:0] Read_Reg1_ID,
    input  logic [ADDR_WIDTH-1:0] Read_Reg2_ID,
    input  logic                  Stall_ID,
    output logic [DATA_WIDTH-1:0] Read_Data1_EX,
    output logic [DATA_WIDTH-1:0] Read_Data2_EX,
    output logic                  Bypass1_EX,
    output logic                  Bypass2_EX
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  byp1_q, byp1_d;
    logic                  byp2_q, byp2_d;

    logic                  wr_en;
    logic                  hit1;
    logic                  hit2;

    // A write to index 0 is treated as no write at all, so it can neither
    // land in the array nor be forwarded to a read port.
    assign wr_en = RegWrite_WB && (Write_Reg_WB != '0);
    assign hit1  = wr_en && (Write_Reg_WB == Read_Reg1_ID);
    assign hit2  = wr_en && (Write_Reg_WB == Read_Reg2_ID);

    // Array next state: writes proceed regardless of Stall_ID.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[Write_Reg_WB] = Write_Data_WB;
        end
    end

    // Read port next state. hit1/hit2 already exclude index 0, so a read of
    // r0 always falls through to the zero path with the bypass flag clear.
    always_comb begin
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        byp1_d = byp1_q;
        byp2_d = byp2_q;
        if (!Stall_ID) begin
            if (hit1) begin
                rd1_d  = Write_Data_WB;
                byp1_d = 1'b1;
            end else begin
                rd1_d  = (Read_Reg1_ID == '0) ? '0 : mem_q[Read_Reg1_ID];
                byp1_d = 1'b0;
            end
            if (hit2) begin
                rd2_d  = Write_Data_WB;
                byp2_d = 1'b1;
            end else begin
                rd2_d  = (Read_Reg2_ID == '0) ? '0 : mem_q[Read_Reg2_ID];
                byp2_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q  <= '0;
            rd2_q  <= '0;
            byp1_q <= 1'b0;
            byp2_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            byp1_q <= byp1_d;
            byp2_q <= byp2_d;
        end
    end

    assign Read_Data1_EX = rd1_q;
    assign Read_Data2_EX = rd2_q;
    assign Bypass1_EX    = byp1_q;
    assign Bypass2_EX    = byp2_q;

endmodule

// File: tb/tb_id_register_file.sv
// ----------------------------------------------------------------------------
// tb_id_register_file
//
// Directed bench for id_register_file. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point. Expected values are
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_id_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic          stall;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          bypass1;
    logic          bypass2;

    int tests_run;
    int tests_failed;

    id_register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RegWrite_WB   (reg_write),
        .Write_Reg_WB  (write_reg),
        .Write_Data_WB (write_data),
        .Read_Reg1_ID  (read_reg1),
        .Read_Reg2_ID  (read_reg2),
        .Stall_ID      (stall),
        .Read_Data1_EX (read_data1),
        .Read_Data2_EX (read_data2),
        .Bypass1_EX    (bypass1),
        .Bypass2_EX    (bypass2)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic st);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        stall      = st;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 1'b0);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_rd1", read_data1, 32'h0);
        check("reset_rd2", read_data2, 32'h0);
        check("reset_byp1", {31'b0, bypass1}, 32'h0);
        check("reset_byp2", {31'b0, bypass2}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Write r5, read it back one cycle later from the array.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0);
        tick();
        check("r5_rd1", read_data1, 32'hDEADBEEF);
        check("r5_byp1", {31'b0, bypass1}, 32'h0);
        check("r0_rd2", read_data2, 32'h0);

        // Same-cycle write and dual read of r7: both ports bypass.
        drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
        tick();
        check("byp_both_rd1", read_data1, 32'h12345678);
        check("byp_both_rd2", read_data2, 32'h12345678);
        check("byp_both_f1", {31'b0, bypass1}, 32'h1);
        check("byp_both_f2", {31'b0, bypass2}, 32'h1);

        // Independent bypass: port1 matches write to r7, port2 reads r5.
        drive(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd5, 1'b0);
        tick();
        check("indep_rd1", read_data1, 32'hCAFEF00D);
        check("indep_f1", {31'b0, bypass1}, 32'h1);
        check("indep_rd2", read_data2, 32'hDEADBEEF);
        check("indep_f2", {31'b0, bypass2}, 32'h0);

        // Write to r0 is discarded and never bypassed.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b0);
        tick();
        check("r0_same_rd1", read_data1, 32'h0);
        check("r0_same_f1", {31'b0, bypass1}, 32'h0);
        check("r7_array_rd2", read_data2, 32'hCAFEF00D);
        tick();
        check("r0_next_rd1", read_data1, 32'h0);
        check("r0_next_f1", {31'b0, bypass1}, 32'h0);

        // Stall holds outputs while array writes still land.
        drive(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0);
        tick();
        check("stall_pre_rd1", read_data1, 32'h11);
        drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_rd1", read_data1, 32'h11);
            check("stall_hold_f2", {31'b0, bypass2}, 32'h0);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0);
        tick();
        check("stall_rel_rd1", read_data1, 32'h22);
        check("stall_rel_f1", {31'b0, bypass1}, 32'h0);

        // RegWrite_WB low leaves the array unchanged.
        drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0, 1'b0);
        tick();
        check("nowe_same_rd1", read_data1, 32'h99);
        check("nowe_same_f1", {31'b0, bypass1}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0);
        tick();
        check("nowe_rd1", read_data1, 32'h99);

        // Fill r1..r31 with their own index values and spot-check.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, i[AW-1:0], DW'(i), 5'd0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd17, 1'b0);
        tick();
        check("fill_r31", read_data1, 32'd31);
        check("fill_r17", read_data2, 32'd17);

        // Mid-sequence reset pulse between edges: outputs clear immediately.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd1", read_data1, 32'h0);
        check("midrst_rd2", read_data2, 32'h0);
        // Writes are ignored while reset is held low.
        drive(1'b1, 5'd2, 32'h5555, 5'd2, 5'd2, 1'b0);
        tick();
        check("inrst_rd1", read_data1, 32'h0);
        check("inrst_f1", {31'b0, bypass1}, 32'h0);
        rst_n = 1'b1;

        // First edge after release performs a normal write with bypass.
        drive(1'b1, 5'd4, 32'h44, 5'd4, 5'd1, 1'b0);
        tick();
        check("rel_rd1", read_data1, 32'h44);
        check("rel_f1", {31'b0, bypass1}, 32'h1);
        check("rel_rd2", read_data2, 32'h0);

        // Every other register was cleared by the reset.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, i[AW-1:0], 5'(32 - i), 1'b0);
            tick();
            check("post_rst_rd1", read_data1, (i == 4) ? 32'h44 : 32'h0);
            check("post_rst_rd2", read_data2, ((32 - i) == 4) ? 32'h44 : 32'h0);
            check("post_rst_f1", {31'b0, bypass1}, 32'h0);
        end

        // Stall also freezes a set bypass flag.
        drive(1'b1, 5'd6, 32'h66, 5'd6, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 32'h88, 5'd0, 5'd0, 1'b1);
        tick();
        check("stall_byp_rd1", read_data1, 32'h66);
        check("stall_byp_f1", {31'b0, bypass1}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
